// File: rtl/floo_tcdm_mux_pkg.sv
// Width helpers shared by the TCDM mux and its index FIFO.
// Index fields keep at least one bit so single-port builds still elaborate.
package floo_tcdm_mux_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Generic register FIFO: 0-cycle read of head, optional fall-through when empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] usage_o,
    input  dtype             data_i,
    input  logic             push_i,
    output dtype             data_o,
    input  logic             pop_i
);

    typedef logic [ADDR_DEPTH-1:0] ptr_t;

    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dtype             mem_q [DEPTH];
    dtype             mem_d [DEPTH];
    logic             push_ok, pop_ok;

    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == ptr_t'(DEPTH - 1)) begin
            return '0;
        end
        return p + ptr_t'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        data_o   = mem_q[rd_ptr_q];
        if (FALL_THROUGH && empty_o && push_i) begin
            data_o = data_i;
        end

        push_ok = push_i && !full_o;
        pop_ok  = pop_i && (!empty_o || (FALL_THROUGH && push_i));

        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/floo_tcdm_mux.sv
// Round-robin N:1 TCDM request mux; responses steered back in order via a port-index FIFO.
// 0-cycle request and response paths; requests blocked while MaxOutstanding are in flight.
module floo_tcdm_mux
    import floo_tcdm_mux_pkg::*;
#(
    parameter int unsigned NumPorts       = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter type         tcdm_req_t     = logic,
    parameter type         tcdm_rsp_t     = logic
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  tcdm_req_t                             in_req_i       [NumPorts],
    input  logic      [NumPorts-1:0]              in_req_valid_i,
    output logic      [NumPorts-1:0]              in_req_ready_o,
    output tcdm_rsp_t                             in_rsp_o       [NumPorts],
    output logic      [NumPorts-1:0]              in_rsp_valid_o,
    input  logic      [NumPorts-1:0]              in_rsp_ready_i,
    output tcdm_req_t                             out_req_o,
    output logic                                  out_req_valid_o,
    input  logic                                  out_req_ready_i,
    input  tcdm_rsp_t                             out_rsp_i,
    input  logic                                  out_rsp_valid_i,
    output logic                                  out_rsp_ready_o,
    output logic [cnt_width(MaxOutstanding)-1:0]  outstanding_o
);

    localparam int unsigned IdxW = idx_width(NumPorts);

    typedef logic [IdxW-1:0] idx_t;

    idx_t rr_ptr_q, rr_ptr_d;
    idx_t sel_idx, cand_idx, head_idx;
    logic any_vld, fifo_full, fifo_empty;
    logic req_hs, rsp_hs;

    function automatic idx_t wrap_inc(input idx_t i);
        if (i == idx_t'(NumPorts - 1)) begin
            return '0;
        end
        return i + idx_t'(1);
    endfunction

    // First valid port at or after rr_ptr, wrapping; only depends on valids, never on ready.
    always_comb begin
        sel_idx  = rr_ptr_q;
        cand_idx = rr_ptr_q;
        any_vld  = 1'b0;
        for (int unsigned k = 0; k < NumPorts; k++) begin
            if (!any_vld && in_req_valid_i[cand_idx]) begin
                sel_idx = cand_idx;
                any_vld = 1'b1;
            end
            cand_idx = wrap_inc(cand_idx);
        end
    end

    // Full is registered, so a pop in the same cycle cannot reopen the request path.
    assign out_req_valid_o = any_vld && !fifo_full && !rst_i;
    assign out_req_o       = in_req_i[sel_idx];
    assign req_hs          = out_req_valid_o && out_req_ready_i;

    always_comb begin
        in_req_ready_o          = '0;
        in_req_ready_o[sel_idx] = out_req_ready_i && out_req_valid_o;
    end

    assign rr_ptr_d = req_hs ? wrap_inc(sel_idx) : rr_ptr_q;

    always_comb begin
        in_rsp_valid_o = '0;
        if (!fifo_empty) begin
            in_rsp_valid_o[head_idx] = out_rsp_valid_i;
        end
        for (int unsigned p = 0; p < NumPorts; p++) begin
            in_rsp_o[p] = out_rsp_i;
        end
    end

    assign out_rsp_ready_o = !fifo_empty && in_rsp_ready_i[head_idx];
    assign rsp_hs          = out_rsp_valid_i && out_rsp_ready_o;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (IdxW),
        .DEPTH        (MaxOutstanding),
        .dtype        (idx_t)
    ) i_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (outstanding_o),
        .data_i  (sel_idx),
        .push_i  (req_hs),
        .data_o  (head_idx),
        .pop_i   (rsp_hs)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // A response with nothing in flight means the chimney and this block disagree.
    rsp_without_req_a : assert property (@(posedge clk_i) disable iff (rst_i)
        out_rsp_valid_i |-> !fifo_empty);

endmodule
